// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel input conditioner: start FSM state
// encoding, default timing constants and door polarity.
package panel_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_PRESSED  = 2'd1;
   localparam state_t ST_WAIT_REL = 2'd2;

   localparam int DEF_DB_CYCLES   = 50000;
   localparam int DEF_LONG_CYCLES = 2000000;
   localparam int DEF_CNT_W       = 21;

   localparam logic DOOR_CLOSED = 1'b1;

endpackage

// File: rtl/panel_input_conditioner_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a WIDTH-bit raw input.
// Any bit change of the synced vector restarts the count.
module debounce
   import panel_pkg::*;
#(
   parameter int WIDTH     = 1,
   parameter int DB_CYCLES = DEF_DB_CYCLES,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] level_o
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // prev_q holds last cycle's synced value so a fresh change restarts the count
   always_comb begin
      sync1_d  = raw_i;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if ((sync2_q == stable_q) || (sync2_q != prev_q)) begin
         cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level_o = stable_q;

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel input stage: debounces door, start and load inputs and turns the
// start button into registered short-press start and long-press abort pulses.
module panel_input_conditioner
   import panel_pkg::*;
#(
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int LONG_CYCLES = DEF_LONG_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       door_raw,
   input  logic       start_raw,
   input  logic [1:0] load_raw,
   output logic       door,
   output logic       start,
   output logic       abort,
   output logic [1:0] load
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

   logic       door_db;
   logic       start_db;
   logic [1:0] load_db;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             start_q, start_d;
   logic             abort_q, abort_d;
   logic [1:0]       load_q, load_d;

   debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_door_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (door_raw),
      .level_o (door_db)
   );

   debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_start_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (start_raw),
      .level_o (start_db)
   );

   debounce #(.WIDTH(2), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_load_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (load_raw),
      .level_o (load_db)
   );

   // Door is only consulted at release, so a mid-press door change is ignored
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      start_d = 1'b0;
      abort_d = 1'b0;
      load_d  = load_q;
      case (state_q)
         ST_IDLE: begin
            if (start_db) begin
               state_d = ST_PRESSED;
               hold_d  = '0;
            end
         end
         ST_PRESSED: begin
            if (!start_db) begin
               state_d = ST_IDLE;
               if (door_db == DOOR_CLOSED) begin
                  start_d = 1'b1;
                  load_d  = load_db;
               end
            end else begin
               hold_d = hold_q + 1'b1;
               if (hold_q == LONG_LAST) begin
                  abort_d = 1'b1;
                  state_d = ST_WAIT_REL;
               end
            end
         end
         ST_WAIT_REL: begin
            if (!start_db) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         start_q <= 1'b0;
         abort_q <= 1'b0;
         load_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         start_q <= start_d;
         abort_q <= abort_d;
         load_q  <= load_d;
      end
   end

   assign door  = door_db;
   assign start = start_q;
   assign abort = abort_q;
   assign load  = load_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench for panel_input_conditioner: each press pushes its expected
// pulse (kind, load, cycle) and a negedge monitor pops and compares.
module tb_panel_input_conditioner;

   localparam int DB   = 4;
   localparam int LONG = 20;
   localparam int CW   = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       door_raw;
   logic       start_raw;
   logic [1:0] load_raw;
   logic       door;
   logic       start;
   logic       abort;
   logic [1:0] load;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       is_abort;
      logic [1:0] load;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   panel_input_conditioner #(
      .DB_CYCLES   (DB),
      .LONG_CYCLES (LONG),
      .CNT_W       (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .door_raw  (door_raw),
      .start_raw (start_raw),
      .load_raw  (load_raw),
      .door      (door),
      .start     (start),
      .abort     (abort),
      .load      (load)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every output pulse must match the oldest expected entry
   always @(negedge clk) begin
      if (rst === 1'b1 && (start === 1'b1 || abort === 1'b1)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_pulse: start=%0b abort=%0b at cycle %0d, no pulse expected",
                     start, abort, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("pulse_start", 32'(start), 32'(!mon_e.is_abort));
            checkOutput("pulse_abort", 32'(abort), 32'(mon_e.is_abort));
            checkOutput("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            checkOutput("pulse_load", 32'(load), 32'(mon_e.load));
         end
      end
   end

   // kind: 0 = no pulse, 1 = start, 2 = abort; load_at is the offset from the
   // press's first sampled edge at which load_raw switches to new_load
   task automatic applyStimulus(input int n, input int kind, input logic [1:0] exp_load,
                                input int load_at, input logic [1:0] new_load);
      int   k;
      exp_t e;
      k = cyc + 1;
      if (kind == 1) begin
         e.is_abort = 1'b0;
         e.load     = exp_load;
         e.cyc      = k + n + DB + 3;
         exp_q.push_back(e);
      end else if (kind == 2) begin
         e.is_abort = 1'b1;
         e.load     = exp_load;
         e.cyc      = k + DB + 3 + LONG;
         exp_q.push_back(e);
      end
      start_raw = 1'b1;
      for (int t = 0; t <= n + 2; t++) begin
         if (t == n) start_raw = 1'b0;
         if (t == load_at) load_raw = new_load;
         @(negedge clk);
      end
      repeat (35) @(negedge clk);
   endtask

   initial begin
      int k;
      int w;
      rst       = 1'b0;
      door_raw  = 1'b0;
      start_raw = 1'b0;
      load_raw  = 2'b00;
      repeat (3) @(negedge clk);
      checkOutput("reset_door", 32'(door), 0);
      checkOutput("reset_start", 32'(start), 0);
      checkOutput("reset_abort", 32'(abort), 0);
      checkOutput("reset_load", 32'(load), 0);
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] door debounce latency");
      door_raw = 1'b1;
      load_raw = 2'b10;
      k = cyc + 1;
      while (cyc < k + DB + 1) @(negedge clk);
      checkOutput("door_before_db", 32'(door), 0);
      @(negedge clk);
      checkOutput("door_after_db", 32'(door), 1);
      repeat (10) @(negedge clk);

      $display("[TB] glitch rejection");
      for (int n = 1; n <= 3; n++) applyStimulus(n, 0, 2'b00, -1, 2'b00);
      door_raw = 1'b0;
      repeat (3) @(negedge clk);
      door_raw = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("door_glitch", 32'(door), 1);

      $display("[TB] short press, door open, long press");
      applyStimulus(10, 1, 2'b10, -1, 2'b00);
      door_raw = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("door_open_level", 32'(door), 0);
      applyStimulus(10, 0, 2'b00, -1, 2'b00);
      checkOutput("load_kept_door_open", 32'(load), 32'(2'b10));
      door_raw = 1'b1;
      repeat (12) @(negedge clk);
      applyStimulus(40, 2, 2'b10, -1, 2'b00);

      $display("[TB] hold and load boundaries");
      applyStimulus(20, 1, 2'b10, -1, 2'b00);
      applyStimulus(21, 2, 2'b10, -1, 2'b00);
      applyStimulus(10, 1, 2'b01, 10, 2'b01);
      applyStimulus(10, 1, 2'b01, 11, 2'b11);
      checkOutput("load_late_not_taken", 32'(load), 32'(2'b01));
      applyStimulus(8, 1, 2'b11, -1, 2'b00);

      $display("[TB] reset during press");
      start_raw = 1'b1;
      repeat (9) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("midreset_door", 32'(door), 0);
      checkOutput("midreset_start", 32'(start), 0);
      checkOutput("midreset_abort", 32'(abort), 0);
      checkOutput("midreset_load", 32'(load), 0);
      start_raw = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("door_after_reset", 32'(door), 1);
      applyStimulus(10, 1, 2'b11, -1, 2'b00);

      w = 0;
      while (exp_q.size() > 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         total++;
         bad++;
         $display("[TB] FAIL missing_pulse: abort=%0b expected at cycle %0d, never seen",
                  mon_e.is_abort, mon_e.cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
